// File: rtl/MD_pkg.sv
// Shared MD types: force packets produced by the PE and their ring-carried form.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package MD_pkg;

  localparam int GLOBAL_CELL_ID_WIDTH = 9;
  localparam int PARTICLE_ID_WIDTH    = 8;
  localparam int FORCE_WIDTH          = 32;

  // Ring size the packed hop field is sized for; a node's RING_NODES
  // parameter must not exceed 2**HOP_WIDTH.
  localparam int FORCE_RING_NODES = 8;
  localparam int HOP_WIDTH        = $clog2(FORCE_RING_NODES);

  typedef struct packed {
    logic [GLOBAL_CELL_ID_WIDTH-1:0] gcid;
    logic [PARTICLE_ID_WIDTH-1:0]    parid;
    logic [FORCE_WIDTH-1:0]          force_x;
    logic [FORCE_WIDTH-1:0]          force_y;
    logic [FORCE_WIDTH-1:0]          force_z;
  } force_pkt_t;

  typedef struct packed {
    logic [GLOBAL_CELL_ID_WIDTH-1:0] gcid;
    logic [PARTICLE_ID_WIDTH-1:0]    parid;
    logic [FORCE_WIDTH-1:0]          force_x;
    logic [FORCE_WIDTH-1:0]          force_y;
    logic [FORCE_WIDTH-1:0]          force_z;
    logic [HOP_WIDTH-1:0]            hops;
  } force_ring_pkt_t;

  // Strip the hop count off a ring packet.
  function automatic force_pkt_t ring_to_force(input force_ring_pkt_t r);
    force_pkt_t f;
    f.gcid    = r.gcid;
    f.parid   = r.parid;
    f.force_x = r.force_x;
    f.force_y = r.force_y;
    f.force_z = r.force_z;
    return f;
  endfunction

  // Wrap a local packet for the ring with a given hop count.
  function automatic force_ring_pkt_t force_to_ring(input force_pkt_t f,
                                                    input logic [HOP_WIDTH-1:0] hops);
    force_ring_pkt_t r;
    r.gcid    = f.gcid;
    r.parid   = f.parid;
    r.force_x = f.force_x;
    r.force_y = f.force_y;
    r.force_z = f.force_z;
    r.hops    = hops;
    return r;
  endfunction

endpackage

// File: rtl/force_inject_fifo.sv
// First-word-fall-through synchronous FIFO holding local packets awaiting injection.
// Latency: a write is visible on dout the cycle after it is written.
// Backpressure: writes while full and reads while empty are ignored; the owner gates wr_en on count.
// Ports: clk/rst, wr_en+din (push), rd_en (pop head), dout (head), empty, count (0..DEPTH).
module force_inject_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign do_wr = wr_en && (count != (AW+1)'(DEPTH));
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/force_output_ring_node.sv
// Force-return ring node: forwards foreign ring traffic, delivers own-cell packets to the cache, injects PE packets.
// Latency: ring-in to ring-out / cache-out is 1 cycle; local packets wait in the FIFO until a free slot.
// Backpressure: ring is never stalled; PE sees o_local_ready (count<DEPTH) and o_pe_back_pressure (almost full).
// Ports: ring in (i_prev_*), PE in (i_local_*), ring out (o_next_*), cache write (o_force_to_cache*), status/counters.
module force_output_ring_node
  import MD_pkg::*;
#(
  parameter logic [2:0] GCELL_X    = 3'b000,
  parameter logic [2:0] GCELL_Y    = 3'b000,
  parameter logic [2:0] GCELL_Z    = 3'b000,
  parameter int         RING_NODES = 8,
  parameter int         FIFO_DEPTH = 16,
  parameter int         AF_MARGIN  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  force_ring_pkt_t i_prev_force_pkt,
  input  logic            i_prev_valid,
  input  force_pkt_t      i_local_force_pkt,
  input  logic            i_local_valid,
  output logic            o_local_ready,
  output logic            o_pe_back_pressure,
  output force_ring_pkt_t o_next_force_pkt,
  output logic            o_next_valid,
  output force_pkt_t      o_force_to_cache,
  output logic            o_force_to_cache_valid,
  output logic            o_orphan_err,
  output logic [15:0]     o_inject_cnt,
  output logic [15:0]     o_deliver_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [GLOBAL_CELL_ID_WIDTH-1:0] LOCAL_GCID = {GCELL_X, GCELL_Y, GCELL_Z};
  localparam logic [HOP_WIDTH-1:0]            LAST_HOP   = HOP_WIDTH'(RING_NODES - 1);

  force_pkt_t      head;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_wr;
  logic            fifo_rd;

  force_ring_pkt_t ring_nxt;
  logic            ring_vld_nxt;
  force_pkt_t      cache_nxt;
  logic            cache_vld_nxt;
  logic            orphan_set;
  logic            inject;

  // Flow-control flags come straight off the registered FIFO count.
  assign o_local_ready      = (fifo_cnt < CW'(FIFO_DEPTH));
  assign o_pe_back_pressure = (fifo_cnt >= CW'(FIFO_DEPTH - AF_MARGIN));
  assign fifo_wr            = i_local_valid && o_local_ready;

  force_inject_fifo #(
    .WIDTH ($bits(force_pkt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (fifo_wr),
    .din   (i_local_force_pkt),
    .rd_en (fifo_rd),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    ring_nxt      = '0;
    ring_vld_nxt  = 1'b0;
    cache_nxt     = '0;
    cache_vld_nxt = 1'b0;
    orphan_set    = 1'b0;
    fifo_rd       = 1'b0;
    inject        = 1'b0;

    // Ring traffic is resolved first and always wins.
    if (i_prev_valid) begin
      if (i_prev_force_pkt.gcid == LOCAL_GCID) begin
        cache_vld_nxt = 1'b1;
        cache_nxt     = ring_to_force(i_prev_force_pkt);
      end else if (i_prev_force_pkt.hops == LAST_HOP) begin
        orphan_set = 1'b1;
      end else begin
        ring_vld_nxt  = 1'b1;
        ring_nxt      = i_prev_force_pkt;
        ring_nxt.hops = i_prev_force_pkt.hops + 1'b1;
      end
    end

    // The FIFO head only moves when ring traffic left the slot free. A
    // head addressed to this cell must also find the cache port unused,
    // otherwise it is held so local order behind ring delivery is kept.
    if (!ring_vld_nxt && !fifo_empty) begin
      if (head.gcid != LOCAL_GCID) begin
        fifo_rd      = 1'b1;
        ring_vld_nxt = 1'b1;
        ring_nxt     = force_to_ring(head, '0);
        inject       = 1'b1;
      end else if (!cache_vld_nxt) begin
        fifo_rd       = 1'b1;
        cache_vld_nxt = 1'b1;
        cache_nxt     = head;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_next_force_pkt       <= '0;
      o_next_valid           <= 1'b0;
      o_force_to_cache       <= '0;
      o_force_to_cache_valid <= 1'b0;
      o_orphan_err           <= 1'b0;
      o_inject_cnt           <= '0;
      o_deliver_cnt          <= '0;
    end else begin
      o_next_force_pkt       <= ring_nxt;
      o_next_valid           <= ring_vld_nxt;
      o_force_to_cache       <= cache_nxt;
      o_force_to_cache_valid <= cache_vld_nxt;
      if (orphan_set)    o_orphan_err  <= 1'b1;
      if (inject)        o_inject_cnt  <= o_inject_cnt + 1'b1;
      if (cache_vld_nxt) o_deliver_cnt <= o_deliver_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_force_output_ring_node.sv
// Self-checking bench for force_output_ring_node: scripted ring/PE stimulus with expected-output queues.
// Latency: outputs compared on the falling edge, one cycle after the driving rising edge.
// Backpressure: PE ready / almost-full checked against a bench-side occupancy count.
module tb_force_output_ring_node;
  import MD_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  force_ring_pkt_t i_prev_force_pkt;
  logic            i_prev_valid;
  force_pkt_t      i_local_force_pkt;
  logic            i_local_valid;
  logic            o_local_ready;
  logic            o_pe_back_pressure;
  force_ring_pkt_t o_next_force_pkt;
  logic            o_next_valid;
  force_pkt_t      o_force_to_cache;
  logic            o_force_to_cache_valid;
  logic            o_orphan_err;
  logic [15:0]     o_inject_cnt;
  logic [15:0]     o_deliver_cnt;

  force_output_ring_node dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_prev_force_pkt       (i_prev_force_pkt),
    .i_prev_valid           (i_prev_valid),
    .i_local_force_pkt      (i_local_force_pkt),
    .i_local_valid          (i_local_valid),
    .o_local_ready          (o_local_ready),
    .o_pe_back_pressure     (o_pe_back_pressure),
    .o_next_force_pkt       (o_next_force_pkt),
    .o_next_valid           (o_next_valid),
    .o_force_to_cache       (o_force_to_cache),
    .o_force_to_cache_valid (o_force_to_cache_valid),
    .o_orphan_err           (o_orphan_err),
    .o_inject_cnt           (o_inject_cnt),
    .o_deliver_cnt          (o_deliver_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;

  force_ring_pkt_t exp_ring[$];
  force_pkt_t      exp_cache[$];
  force_ring_pkt_t pend_ring[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic force_pkt_t mk_loc(input int gcid, input int parid);
    force_pkt_t f;
    f.gcid    = GLOBAL_CELL_ID_WIDTH'(gcid);
    f.parid   = PARTICLE_ID_WIDTH'(parid);
    f.force_x = 32'h3f80_0000 + 32'(parid);
    f.force_y = 32'hc120_0000 ^ (32'(parid) << 8);
    f.force_z = 32'h4049_0fdb - 32'(parid * 3);
    return f;
  endfunction

  function automatic force_ring_pkt_t mk_ring(input int gcid, input int parid, input int hops);
    force_pkt_t f;
    force_ring_pkt_t r;
    f = mk_loc(gcid, parid);
    r.gcid    = f.gcid;
    r.parid   = f.parid;
    r.force_x = f.force_x;
    r.force_y = f.force_y;
    r.force_z = f.force_z;
    r.hops    = HOP_WIDTH'(hops);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every valid output must match the head of its expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_next_valid) begin
        if (exp_ring.size() == 0) chk("ring_unexpected", 128'(o_next_valid), 128'(0));
        else chk("ring_pkt", 128'(o_next_force_pkt), 128'(exp_ring.pop_front()));
      end
      if (o_force_to_cache_valid) begin
        if (exp_cache.size() == 0) chk("cache_unexpected", 128'(o_force_to_cache_valid), 128'(0));
        else chk("cache_pkt", 128'(o_force_to_cache), 128'(exp_cache.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin
    int mc;
    force_pkt_t lp;
    rst = 1'b1;
    i_prev_force_pkt  = '0;
    i_prev_valid      = 1'b0;
    i_local_force_pkt = '0;
    i_local_valid     = 1'b0;

    // 1. reset
    repeat (10) tick();
    rst = 1'b0;
    chk("rst_next_valid",  128'(o_next_valid),           128'(0));
    chk("rst_cache_valid", 128'(o_force_to_cache_valid), 128'(0));
    chk("rst_orphan",      128'(o_orphan_err),           128'(0));
    chk("rst_inject_cnt",  128'(o_inject_cnt),           128'(0));
    chk("rst_deliver_cnt", 128'(o_deliver_cnt),          128'(0));
    chk("rst_ready",       128'(o_local_ready),          128'(1));
    chk("rst_bp",          128'(o_pe_back_pressure),     128'(0));
    chk("rst_next_pkt",    128'(o_next_force_pkt),       128'(0));
    mon_en = 1'b1;
    tick();

    // 2. pass-through
    i_prev_force_pkt = mk_ring(2, 5, 2);
    i_prev_valid     = 1'b1;
    exp_ring.push_back(mk_ring(2, 5, 3));
    tick();
    i_prev_valid = 1'b0;
    chk("pass_next_valid", 128'(o_next_valid), 128'(1));
    chk("pass_no_cache",   128'(o_force_to_cache_valid), 128'(0));
    tick();

    // 3a. delivery to own cell
    i_prev_force_pkt = mk_ring(0, 7, 4);
    i_prev_valid     = 1'b1;
    exp_cache.push_back(mk_loc(0, 7));
    tick();
    i_prev_valid = 1'b0;
    chk("deliver_cnt_1", 128'(o_deliver_cnt), 128'(1));
    tick();

    // 3b. orphan on last hop
    i_prev_force_pkt = mk_ring(4, 8, 7);
    i_prev_valid     = 1'b1;
    tick();
    i_prev_valid = 1'b0;
    chk("orphan_set", 128'(o_orphan_err), 128'(1));
    chk("orphan_no_fwd", 128'(o_next_valid), 128'(0));
    repeat (3) tick();
    chk("orphan_sticky", 128'(o_orphan_err), 128'(1));

    // 4. ring busy every cycle while PE pushes 20 packets
    mc = 0;
    for (int i = 0; i < 20; i++) begin
      chk("prio_ready", 128'(o_local_ready),      128'(mc < 16));
      chk("prio_bp",    128'(o_pe_back_pressure), 128'(mc >= 12));
      i_prev_force_pkt  = mk_ring(3, 100 + i, 0);
      i_prev_valid      = 1'b1;
      exp_ring.push_back(mk_ring(3, 100 + i, 1));
      i_local_force_pkt = mk_loc(2, i);
      i_local_valid     = 1'b1;
      if (mc < 16) begin
        pend_ring.push_back(mk_ring(2, i, 0));
        mc++;
      end
      tick();
    end
    i_prev_valid  = 1'b0;
    i_local_valid = 1'b0;
    chk("prio_inject_held", 128'(o_inject_cnt), 128'(0));
    while (pend_ring.size() != 0) exp_ring.push_back(pend_ring.pop_front());
    repeat (18) tick();
    chk("prio_inject_cnt", 128'(o_inject_cnt),  128'(16));
    chk("prio_ready_back", 128'(o_local_ready), 128'(1));
    chk("prio_drained",    128'(exp_ring.size()), 128'(0));

    // 5. collision on the cache port
    i_prev_force_pkt  = mk_ring(3, 200, 0);
    i_prev_valid      = 1'b1;
    exp_ring.push_back(mk_ring(3, 200, 1));
    i_local_force_pkt = mk_loc(0, 50);
    i_local_valid     = 1'b1;
    tick();
    i_local_valid    = 1'b0;
    i_prev_force_pkt = mk_ring(0, 60, 5);
    exp_cache.push_back(mk_loc(0, 60));
    lp = mk_loc(0, 50);
    exp_cache.push_back(lp);
    tick();
    i_prev_valid = 1'b0;
    chk("coll_ring_first", 128'(o_force_to_cache.parid), 128'(60));
    tick();
    chk("coll_local_next", 128'(o_force_to_cache_valid), 128'(1));
    tick();
    chk("coll_deliver_cnt", 128'(o_deliver_cnt), 128'(3));
    chk("coll_inject_cnt",  128'(o_inject_cnt),  128'(16));

    // 6. reset with 5 packets buffered
    for (int i = 0; i < 5; i++) begin
      i_prev_force_pkt  = mk_ring(5, 150 + i, 1);
      i_prev_valid      = 1'b1;
      exp_ring.push_back(mk_ring(5, 150 + i, 2));
      i_local_force_pkt = mk_loc(2, 20 + i);
      i_local_valid     = 1'b1;
      tick();
    end
    i_prev_valid  = 1'b0;
    i_local_valid = 1'b0;
    chk("mid_bp_cnt5", 128'(o_pe_back_pressure), 128'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_next_valid",  128'(o_next_valid),           128'(0));
    chk("mid_cache_valid", 128'(o_force_to_cache_valid), 128'(0));
    chk("mid_ready",       128'(o_local_ready),          128'(1));
    chk("mid_orphan",      128'(o_orphan_err),           128'(0));
    chk("mid_inject_cnt",  128'(o_inject_cnt),           128'(0));
    chk("mid_deliver_cnt", 128'(o_deliver_cnt),          128'(0));
    repeat (20) tick();
    chk("mid_no_stale_inject", 128'(o_inject_cnt), 128'(0));

    chk("ring_q_empty",  128'(exp_ring.size()),  128'(0));
    chk("cache_q_empty", 128'(exp_cache.size()), 128'(0));
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/force_output_ring_node.md
Name: force_output_ring_node

Overview:
One node of the force-return ring, the reverse path of the position input ring. It collects force packets produced by the local PE and injects them into the ring. It forwards ring traffic bound for other cells and delivers packets addressed to its own global cell to the local force cache. Ring traffic always has priority over local injection. Local packets wait in an internal FWFT FIFO that applies back pressure to the PE.

Parameters:
GCELL_X, 3'b000, x coordinate of this node's global cell
GCELL_Y, 3'b000, y coordinate of this node's global cell
GCELL_Z, 3'b000, z coordinate of this node's global cell
RING_NODES, 8, number of nodes on the ring
FIFO_DEPTH, 16, local injection FIFO depth (power of 2)
AF_MARGIN, 4, almost-full margin for PE back pressure

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_prev_force_pkt  in  force_ring_pkt_t  packet from previous node
i_prev_valid  in  1  previous-node packet valid
i_local_force_pkt  in  force_pkt_t  PE force packet {gcid, parid, force_x/y/z}
i_local_valid  in  1  PE packet valid
o_local_ready  out  1  FIFO can accept (count < FIFO_DEPTH)
o_pe_back_pressure  out  1  count >= FIFO_DEPTH-AF_MARGIN
o_next_force_pkt  out  force_ring_pkt_t  packet to next node
o_next_valid  out  1  next-node packet valid
o_force_to_cache  out  force_pkt_t  packet for local force cache
o_force_to_cache_valid  out  1  cache write strobe
o_orphan_err  out  1  sticky, set when a packet exhausts its hops
o_inject_cnt  out  16  local packets injected onto the ring (wraps)
o_deliver_cnt  out  16  packets delivered to the cache (wraps)

Behaviour:
- Clocking and reset: single clock; reset is synchronous, active-high.
- Reset values: all outputs 0 except o_local_ready=1. FIFO is emptied. Reset mid-operation drops all in-flight and buffered packets.
- LOCAL_GCID = {GCELL_X, GCELL_Y, GCELL_Z}, 9 bits.
- Ring packet type force_ring_pkt_t = {gcid[8:0], parid, force_x/y/z (32b fp each), hops[HOP_WIDTH]}, with HOP_WIDTH=$clog2(RING_NODES).
- All outputs are registered; ring-in to ring-out latency is 1 cycle.
- Per-cycle priority for a ring input (i_prev_valid=1):
  1. gcid==LOCAL_GCID: deliver to the cache next cycle; the ring slot is free.
  2. Else if hops==RING_NODES-1: drop the packet, set o_orphan_err; the slot is free.
  3. Else: forward with hops+1; the slot is occupied.
- Local FIFO head, handled only if the slot is free and the FIFO is non-empty:
  - Head gcid!=LOCAL_GCID and slot free: pop, drive it on o_next with hops=0, o_inject_cnt++.
  - Head gcid==LOCAL_GCID and the cache port is unused this cycle: pop and deliver to the cache.
  - Head gcid==LOCAL_GCID but the cache port is taken by ring traffic: hold the head and do not pop.
- At most one ring output and one cache write per cycle. o_deliver_cnt increments on each cache write.
- Ring traffic is never stalled; there is no downstream ready on the ring.
- FIFO write occurs when i_local_valid && o_local_ready.
  - Simultaneous push and pop are allowed and leave the count unchanged.
  - When full, ready=0 and the input is ignored.
  - o_local_ready and o_pe_back_pressure are computed from the registered count.
- Counters wrap 0xFFFF->0. o_orphan_err clears only on rst.

Decomposition:
- MD_pkg gains force_pkt_t, force_ring_pkt_t and FORCE_WIDTH=32.
- MD_pkg reuses GLOBAL_CELL_ID_WIDTH and PARTICLE_ID_WIDTH.
- Sub-module force_inject_fifo: FWFT synchronous FIFO.
  - Parameterised width and depth.
  - Ports: wr_en, din, rd_en, dout, empty, count.

Test Plan:
1. Reset: rst high for 10 cycles, then release -> all outputs 0, o_local_ready=1, counters 0.
2. Pass-through: GCELL=000. Ring packet with gcid=9'b000000010, hops=2, parid=5 -> next cycle o_next_valid=1, hops=3, parid=5; no cache write.
3. Delivery and orphan:
   - Ring packet gcid=0 -> o_force_to_cache_valid=1 next cycle with identical forces; o_deliver_cnt=1.
   - Ring packet gcid=9'b000000100, hops=7 -> dropped, o_orphan_err=1 and stays 1.
4. Priority: ring forwards every cycle while the PE pushes 20 packets to gcid=2.
   - o_local_ready drops after 16 accepted; o_pe_back_pressure rises at count 12.
   - After ring traffic stops, the 16 packets are injected over 16 consecutive cycles with hops=0; o_inject_cnt=16.
5. Collision: ring packet and FIFO head both gcid=0 in the same cycle -> ring packet goes to the cache first, the local packet the following cycle; order preserved.
6. Reset mid-operation: rst for one cycle with FIFO count=5 -> FIFO empty, o_next_valid=0 next cycle, no stale delivery afterwards.
